// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SPI memory (64 x 8) among NUM_REQ requesters.
// Define SPI_MEM_ARB_TIMEOUT_EN to add the watchdog (ISSUE abort, DRAIN state, bounded RELEASE).
module spi_mem_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_cmd,
    input  logic [6*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [1:0]           mem_cmd,
    output logic [5:0]           mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 mem_en,
    input  logic                 mem_valid
);
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned CMD_W  = 2;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("spi_mem_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 8) begin : g_bad_timeout
        $error("spi_mem_arbiter: TIMEOUT_CYCLES must be >= 8");
    end

`ifdef SPI_MEM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam int unsigned          CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    w_last_nxt;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    w_grant_nxt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_mem_en;
    logic                w_mem_en_nxt;
    logic [CMD_W-1:0]    r_mem_cmd;
    logic [CMD_W-1:0]    w_mem_cmd_nxt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;

    logic [CMD_W-1:0]    w_cmd_arr   [NUM_REQ];
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic                w_found;
    logic [IDX_W-1:0]    w_win;
    logic [IDX_W-1:0]    w_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_cmd_arr[gi]   = req_cmd[gi*CMD_W +: CMD_W];
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Round-robin pick: first set req bit searching from last+1, wrapping modulo NUM_REQ.
    always_comb begin : rr_pick
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((32'(r_last) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin : fsm_next
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_grant_nxt     = r_grant;
        w_ack_nxt       = '0;
        w_rdata_nxt     = r_rdata;
        w_mem_cmd_nxt   = r_mem_cmd;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
        w_cnt_nxt       = '0;
        w_err_nxt       = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_last_nxt      = w_win;
                    w_grant_nxt     = w_win;
                    w_mem_cmd_nxt   = w_cmd_arr[w_win];
                    w_mem_addr_nxt  = w_addr_arr[w_win];
                    w_mem_wdata_nxt = w_wdata_arr[w_win];
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_valid) begin
                    w_ack_nxt[r_grant] = 1'b1;
                    w_rdata_nxt        = mem_rdata;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
                    w_err_nxt          = 1'b0;
`endif
                    w_state_nxt        = S_RELEASE;
                end
`ifdef SPI_MEM_ARB_TIMEOUT_EN
                // Memory never answered: abort with an error response and let it settle in DRAIN.
                else if (r_cnt == CNT_MAX) begin
                    w_ack_nxt[r_grant] = 1'b1;
                    w_rdata_nxt        = '0;
                    w_err_nxt          = 1'b1;
                    w_state_nxt        = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_RELEASE: begin
                if (!mem_valid) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef SPI_MEM_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
`ifdef SPI_MEM_ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (r_cnt == CNT_MAX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // mem_en and busy are pure functions of the next state, so both come out registered.
        w_mem_en_nxt = (w_state_nxt == S_ISSUE);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_cmd   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_ack       <= w_ack_nxt;
            r_rdata     <= w_rdata_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_cmd   <= w_mem_cmd_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign ack       = r_ack;
    assign rsp_rdata = r_rdata;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_cmd   = r_mem_cmd;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
`ifdef SPI_MEM_ARB_TIMEOUT_EN
    assign rsp_err   = r_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16) with a behavioural memory.
// Watchdog scenarios run when SPI_MEM_ARB_TIMEOUT_EN is defined.
module tb_spi_mem_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
    localparam logic [1:0] CMD_WR = 2'b01;
    localparam logic [1:0] CMD_RD = 2'b10;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [2*N-1:0] req_cmd   = '0;
    logic [6*N-1:0] req_addr  = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   ack;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           busy;
    logic [1:0]     mem_cmd;
    logic [5:0]     mem_addr;
    logic [7:0]     mem_wdata;
    logic [7:0]     mem_rdata;
    logic           mem_en;
    logic           mem_valid;

    always #5 clk = ~clk;

    spi_mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_valid(mem_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] init_val(input int a);
        return (a == 0) ? 8'h00 : 8'((a * 7 + 3) & 255);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural memory: answers mem_en after m_lat cycles, drops valid once mem_en is low.
    logic [7:0] mem [64];
    bit  mem_inited = 1'b0;
    int  m_lat   = 0;
    bit  m_stall = 1'b0;
    int  m_cnt   = 0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_inited <= 1'b1;
            mem_valid  <= 1'b0;
            mem_rdata  <= 8'h00;
            m_cnt      <= 0;
        end else if (mem_en && !mem_valid) begin
            if (m_stall) begin
                m_cnt <= 0;
            end else if (m_cnt >= m_lat) begin
                mem_valid <= 1'b1;
                m_cnt     <= 0;
                if (mem_cmd == CMD_WR) mem[mem_addr] <= mem_wdata;
                mem_rdata <= (mem_cmd == CMD_RD) ? mem[mem_addr] : 8'hEE;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0;
            if (!mem_en) mem_valid <= 1'b0;
        end
    end

    // Scoreboard: expectations pushed when a request is driven, popped on each ack.
    typedef struct {
        int         idx;
        logic [7:0] rdata;
        bit         chk_rd;
        bit         err;
    } exp_t;
    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] shadow [64];

    task automatic expect_txn(input int idx, input logic [1:0] cmd, input logic [5:0] a,
                              input logic [7:0] d);
        exp_t e;
        e.idx = idx;
        e.err = 1'b0;
        if (cmd == CMD_WR) begin
            shadow[a] = d;
            e.rdata   = 8'h00;
            e.chk_rd  = 1'b0;
        end else begin
            e.rdata  = shadow[a];
            e.chk_rd = 1'b1;
        end
        sbq.push_back(e);
    endtask

    logic        prev_en    = 1'b0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_fields = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en    <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (ack != '0) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack=%b, required none (t=%0t)", ack, $time);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ack_onehot", 32'(ack), 32'(1) << mon_e.idx);
                    if (mon_e.chk_rd) check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
            end
            if (mem_en && !prev_en) check("en_rise_while_valid", 32'(prev_valid), 32'd0);
            if (mem_en && prev_en && {mem_cmd, mem_addr, mem_wdata} != prev_fields) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mem_fields_stable: got 0x%0h, required 0x%0h (t=%0t)",
                         {mem_cmd, mem_addr, mem_wdata}, prev_fields, $time);
            end
            prev_en     <= mem_en;
            prev_valid  <= mem_valid;
            prev_fields <= {mem_cmd, mem_addr, mem_wdata};
        end
    end

    task automatic set_req(input int idx, input logic [1:0] cmd, input logic [5:0] a,
                           input logic [7:0] d);
        req_cmd[2*idx +: 2]   = cmd;
        req_addr[6*idx +: 6]  = a;
        req_wdata[8*idx +: 8] = d;
        req[idx]              = 1'b1;
    endtask

    task automatic wait_any_ack(input int budget, input bit drop, output logic [N-1:0] got);
        got = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                got = ack;
                if (drop) req = req & ~ack;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ack_timeout: got no ack, required one within %0d cycles", budget);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: busy still 1, required 0 within %0d cycles", budget);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},       32'(ack),       32'd0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_mem_en"},    32'(mem_en),    32'd0);
        check({tag, "_mem_cmd"},   32'(mem_cmd),   32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    typedef struct {
        int         idx;
        logic [1:0] cmd;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         lat;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [N-1:0] got;
        int           nacks;
        int           cyc;
        int           nb;
        exp_t         e;

        for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
        tbl[0] = '{0, CMD_WR, 6'h15, 8'hA5, 0};
        tbl[1] = '{0, CMD_RD, 6'h15, 8'h00, 2};
        tbl[2] = '{2, CMD_WR, 6'h2A, 8'h3C, 1};
        tbl[3] = '{2, CMD_RD, 6'h2A, 8'h00, 0};
        tbl[4] = '{1, CMD_RD, 6'h07, 8'h00, 1};
        tbl[5] = '{3, CMD_WR, 6'h30, 8'h69, 3};
        tbl[6] = '{3, CMD_RD, 6'h30, 8'h00, 1};
        tbl[7] = '{1, CMD_RD, 6'h15, 8'h00, 0};

        // Reset values
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table: single-requester transactions, one at a time
        for (int v = 0; v < 8; v++) begin
            wait_idle(50);
            m_lat = tbl[v].lat;
            expect_txn(tbl[v].idx, tbl[v].cmd, tbl[v].addr, tbl[v].wdata);
            set_req(tbl[v].idx, tbl[v].cmd, tbl[v].addr, tbl[v].wdata);
            @(negedge clk);
            check("grant_busy",      32'(busy),      32'd1);
            check("grant_mem_en",    32'(mem_en),    32'd1);
            check("grant_mem_cmd",   32'(mem_cmd),   32'(tbl[v].cmd));
            check("grant_mem_addr",  32'(mem_addr),  32'(tbl[v].addr));
            check("grant_mem_wdata", 32'(mem_wdata), 32'(tbl[v].wdata));
            wait_any_ack(50, 1'b1, got);
        end

        // Two requesters held from reset: strict alternation 0,1,0,1,...
        wait_idle(50);
        rst_n = 1'b0;
        m_lat = 1;
        set_req(0, CMD_RD, 6'h15, 8'h00);
        set_req(1, CMD_RD, 6'h07, 8'h00);
        for (int k = 0; k < 4; k++) begin
            expect_txn(0, CMD_RD, 6'h15, 8'h00);
            expect_txn(1, CMD_RD, 6'h07, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_any_ack(60, 1'b0, got);
            check("rr_order", 32'(got), 32'(1) << (k % 2));
        end
        req = '0;

        // After reset (last=3): req1 read and req3 write together, req1 first
        wait_idle(50);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_lat = 2;
        expect_txn(1, CMD_RD, 6'h00, 8'h00);
        expect_txn(3, CMD_WR, 6'h3F, 8'h5A);
        set_req(3, CMD_WR, 6'h3F, 8'h5A);
        set_req(1, CMD_RD, 6'h00, 8'h00);
        wait_any_ack(60, 1'b1, got);
        check("pair_first", 32'(got), 32'h2);
        wait_any_ack(60, 1'b1, got);
        check("pair_second", 32'(got), 32'h8);
        wait_idle(50);
        expect_txn(2, CMD_RD, 6'h3F, 8'h00);
        set_req(2, CMD_RD, 6'h3F, 8'h00);
        wait_any_ack(60, 1'b1, got);

        // Reset two cycles into ISSUE; pending req0 must win over req1 afterwards
        wait_idle(50);
        m_lat = 10;
        set_req(1, CMD_RD, 6'h07, 8'h00);
        @(negedge clk);
        set_req(0, CMD_RD, 6'h15, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_lat = 1;
        @(negedge clk);
        rst_n = 1'b1;
        expect_txn(0, CMD_RD, 6'h15, 8'h00);
        expect_txn(1, CMD_RD, 6'h07, 8'h00);
        wait_any_ack(60, 1'b1, got);
        check("postreset_first", 32'(got), 32'h1);
        wait_any_ack(60, 1'b1, got);
        check("postreset_second", 32'(got), 32'h2);

        // req0 dropped right after its grant: transaction still completes, exactly once
        wait_idle(50);
        m_lat = 3;
        expect_txn(0, CMD_WR, 6'h22, 8'h77);
        set_req(0, CMD_WR, 6'h22, 8'h77);
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        nacks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack[0]) nacks++;
        end
        check("dropped_req_single_ack", 32'(nacks), 32'd1);
        expect_txn(2, CMD_RD, 6'h22, 8'h00);
        set_req(2, CMD_RD, 6'h22, 8'h00);
        wait_any_ack(60, 1'b1, got);

`ifdef SPI_MEM_ARB_TIMEOUT_EN
        // Memory never answers: error ack after TO ISSUE cycles, then TO cycles of DRAIN
        wait_idle(50);
        m_stall  = 1'b1;
        e.idx    = 0;
        e.rdata  = 8'h00;
        e.chk_rd = 1'b1;
        e.err    = 1'b1;
        sbq.push_back(e);
        set_req(0, CMD_RD, 6'h15, 8'h00);
        cyc = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(negedge clk);
            if (ack[0]) begin
                cyc    = i;
                req[0] = 1'b0;
                break;
            end
        end
        check("timeout_ack_cycle", 32'(cyc), 32'(TO + 1));
        nb = 0;
        while (busy && nb < 4 * TO) begin
            nb++;
            @(negedge clk);
        end
        check("timeout_drain_busy", 32'(nb), 32'(TO));
        m_stall = 1'b0;
        expect_txn(0, CMD_RD, 6'h15, 8'h00);
        set_req(0, CMD_RD, 6'h15, 8'h00);
        wait_any_ack(60, 1'b1, got);
        check("after_timeout_ack", 32'(got), 32'h1);
`else
        // Without the watchdog a silent memory keeps the arbiter waiting in ISSUE
        wait_idle(50);
        m_stall = 1'b1;
        set_req(0, CMD_RD, 6'h15, 8'h00);
        nacks = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            @(negedge clk);
            if (ack != '0) nacks++;
        end
        check("stall_no_ack", 32'(nacks), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_mem_en", 32'(mem_en), 32'd1);
        req    = '0;
        rst_n  = 1'b0;
        m_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_txn(0, CMD_RD, 6'h15, 8'h00);
        set_req(0, CMD_RD, 6'h15, 8'h00);
        wait_any_ack(60, 1'b1, got);
        check("after_stall_ack", 32'(got), 32'h1);
`endif

        wait_idle(50);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Round-robin arbiter that shares the single-port SPI memory (64 × 8-bit, `cmd`/`addr`/`wr_data`/`rd_data` with `en`/`valid` four-phase handshake) among `NUM_REQ` requesters. It sits between the requesting engines and the memory. For each request it latches the request and drives one complete memory handshake, then returns read data and a one-cycle acknowledge to the winner. Optionally, a watchdog aborts transactions the memory never completes.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles, ≥8. Used only when `SPI_MEM_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `NUM_REQ`: per-requester request level.
- `req_cmd` in `2*NUM_REQ`: packed commands; requester i is bits `[2i+1:2i]`; codes from `spi_mem_cmd.vh`.
- `req_addr` in `6*NUM_REQ`: packed addresses; requester i is bits `[6i+5:6i]`.
- `req_wdata` in `8*NUM_REQ`: packed write data; requester i is bits `[8i+7:8i]`.
- `ack` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `rsp_rdata` out 8: read data returned with `ack`.
- `rsp_err` out 1: high with `ack` when the transaction was aborted.
- `busy` out 1: high whenever the arbiter is not in IDLE.
- `mem_cmd` out 2, `mem_addr` out 6, `mem_wdata` out 8: latched command to the memory.
- `mem_rdata` in 8: memory read data.
- `mem_en` out 1: memory request.
- `mem_valid` in 1: memory completion.

## Operation
- States: IDLE, ISSUE, RELEASE, DRAIN. DRAIN exists only when `SPI_MEM_ARB_TIMEOUT_EN` is defined.
- **IDLE**:
  - If any `req` bit is set, select the winner by round-robin, searching from `last+1` modulo `NUM_REQ`.
  - Latch the winner's `cmd`/`addr`/`wdata` into `mem_*` and store the grant index.
  - Set `last` to the winner and go to ISSUE.
- **ISSUE**:
  - `mem_en`=1; `mem_cmd`/`mem_addr`/`mem_wdata` are held constant.
  - When `mem_valid`=1 is sampled:
    - capture `mem_rdata` into `rsp_rdata` (captured for every cmd code; undefined content on writes is acceptable);
    - pulse `ack[grant]`, `rsp_err`=0;
    - go to RELEASE.
- **RELEASE**: `mem_en`=0. When `mem_valid`=0 is sampled, go to IDLE.
- `cmd` is passed through unmodified; the arbiter does not interpret it.
- The transaction is committed once latched. Dropping `req` before `ack` does not cancel it; `ack` still pulses.
- A requester holding `req` after its `ack` is treated as a new request and is arbitrated on the next IDLE cycle.
- Non-requesting inputs are ignored. A requester's `req_*` fields are sampled only in the IDLE cycle in which it wins.
- Reset (any time, including mid-ISSUE):
  - all outputs go to 0: `ack`, `rsp_rdata`, `rsp_err`, `busy`, `mem_en`, `mem_cmd`, `mem_addr`, `mem_wdata`;
  - state goes to IDLE;
  - `last`=`NUM_REQ-1`, so requester 0 has first priority;
  - the watchdog counter is cleared.

## Timing
- Request to memory: `req` sampled at edge t in IDLE gives `mem_en`=1 after edge t.
- `mem_en` falls on the same edge at which `mem_valid`=1 is first sampled. `ack` is high for exactly the following cycle, together with `rsp_rdata` and `rsp_err`.
- `rsp_rdata` and `rsp_err` hold their values until the next `ack`.
- `mem_en` never rises while `mem_valid`=1. The minimum gap between transactions is RELEASE plus one IDLE cycle.
- `busy` is registered: high from the cycle after the grant until IDLE is re-entered.
- At most one `ack` bit is set in any cycle.

## Configuration
- `SPI_MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs in ISSUE, starting at 0 on entry.
  - If it reaches `TIMEOUT_CYCLES` without `mem_valid`, the arbiter drops `mem_en` and pulses `ack[grant]` with `rsp_err`=1 and `rsp_rdata`=0.
  - It then enters DRAIN, holds `mem_en`=0 for `TIMEOUT_CYCLES` cycles, and returns to IDLE regardless of `mem_valid`.
  - This also makes RELEASE bounded: after `TIMEOUT_CYCLES` waiting for `mem_valid`=0, go to IDLE.
- `SPI_MEM_ARB_TIMEOUT_EN` undefined: no counter and no DRAIN; ISSUE and RELEASE wait indefinitely, and `rsp_err` is tied 0.

## Test plan
- Single requester, `NUM_REQ`=2: req0 writes `addr`=0x15, `wdata`=0xA5, then reads 0x15. Expect two `ack[0]` pulses, `rsp_rdata`=0xA5 on the second, and `rsp_err`=0.
- Both requesters held from reset, each doing four reads. Expect `ack` order 0,1,0,1,0,1,0,1, with `mem_en` never high while `mem_valid`=1.
- `NUM_REQ`=4: req3 write `addr`=0x3F, `wdata`=0x5A, together with req1 read of `addr`=0x00. Expect req1 acked first with `rsp_rdata`=0x00, then req3 acked; `mem_addr` stays stable throughout each ISSUE.
- Reset asserted 2 cycles into ISSUE. Expect all outputs 0 immediately. After release, a pending req0 is granted before req1.
- req0 deasserted one cycle after grant. Expect the transaction to complete and `ack[0]` to pulse once, with no second transaction.
- `SPI_MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `mem_valid` tied 0:
  - Expect `ack[0]` with `rsp_err`=1 and `rsp_rdata`=0 after 16 ISSUE cycles.
  - Expect `busy` to stay high for 16 further cycles, then the next request to be served normally.
